// File: rtl/issue_scoreboard_if.sv
// Decode/writeback bundle between the decode stage and the issue scoreboard.
// The master (decode) drives the lane and writeback fields; the scoreboard returns grants and its state.
interface issue_scoreboard_if #(
    parameter int LANES    = 2,
    parameter int NUM_REGS = 64,
    parameter int REG_W    = $clog2(NUM_REGS),
    parameter int CNT_W    = $clog2(NUM_REGS + 1)
);
    logic [LANES-1:0]            lane_valid_in;
    logic [LANES-1:0][REG_W-1:0] lane_rs1_in;
    logic [LANES-1:0]            lane_rs1_used_in;
    logic [LANES-1:0][REG_W-1:0] lane_rs2_in;
    logic [LANES-1:0]            lane_rs2_used_in;
    logic [LANES-1:0][REG_W-1:0] lane_rd_in;
    logic [LANES-1:0]            lane_rd_used_in;
    logic [LANES-1:0]            lane_grant_out;
    logic [LANES-1:0]            lane_fire_in;
    logic [LANES-1:0]            wb_valid_in;
    logic [LANES-1:0][REG_W-1:0] wb_reg_in;
    logic                        flush_in;
    logic [NUM_REGS-1:0]         busy_out;
    logic [CNT_W-1:0]            outstanding_out;
    logic                        error_out;

    modport master (
        output lane_valid_in, lane_rs1_in, lane_rs1_used_in, lane_rs2_in, lane_rs2_used_in,
               lane_rd_in, lane_rd_used_in, lane_fire_in, wb_valid_in, wb_reg_in, flush_in,
        input  lane_grant_out, busy_out, outstanding_out, error_out
    );

    modport slave (
        input  lane_valid_in, lane_rs1_in, lane_rs1_used_in, lane_rs2_in, lane_rs2_used_in,
               lane_rd_in, lane_rd_used_in, lane_fire_in, wb_valid_in, wb_reg_in, flush_in,
        output lane_grant_out, busy_out, outstanding_out, error_out
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Register-busy scoreboard: grants an in-order prefix of the decode bundle when hazard-free,
// marks issued destinations busy and clears them on writeback.
module issue_scoreboard #(
    parameter int LANES    = 2,
    parameter int NUM_REGS = 64,
    parameter int REG_W    = $clog2(NUM_REGS),
    parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    issue_scoreboard_if.slave bus
);
    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;
    logic [CNT_W-1:0]    outstanding_reg;
    logic                error_reg;
    logic                error_next;
    logic [LANES-1:0]    hazard;
    logic [LANES-1:0]    grant;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int b = 0; b < NUM_REGS; b++) begin
            cnt = cnt + CNT_W'(v[b]);
        end
        return cnt;
    endfunction

    // Hazards look only at registered busy bits, so a writeback frees its register one cycle later.
    // r0 is never busy, so reads of r0 never stall.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic intra;
            logic busy_hit;

            always_comb begin
                intra = 1'b0;
                for (int k = 0; k < gi; k++) begin
                    if (bus.lane_rd_used_in[k] && (bus.lane_rd_in[k] != '0)) begin
                        if ((bus.lane_rs1_used_in[gi] && (bus.lane_rs1_in[gi] == bus.lane_rd_in[k])) ||
                            (bus.lane_rs2_used_in[gi] && (bus.lane_rs2_in[gi] == bus.lane_rd_in[k])) ||
                            (bus.lane_rd_used_in[gi]  && (bus.lane_rd_in[gi]  == bus.lane_rd_in[k]))) begin
                            intra = 1'b1;
                        end
                    end
                end
            end

            assign busy_hit = (bus.lane_rs1_used_in[gi] & busy_reg[bus.lane_rs1_in[gi]]) |
                              (bus.lane_rs2_used_in[gi] & busy_reg[bus.lane_rs2_in[gi]]) |
                              (bus.lane_rd_used_in[gi]  & busy_reg[bus.lane_rd_in[gi]]);

            assign hazard[gi] = bus.lane_valid_in[gi] & (busy_hit | intra);
        end
    endgenerate

    always_comb begin
        logic prefix;
        grant  = '0;
        prefix = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            grant[i] = prefix & bus.lane_valid_in[i] & ~hazard[i];
            prefix   = grant[i];
        end
    end

    // Clears are applied before sets so an issue to the same register wins.
    always_comb begin
        busy_next  = busy_reg;
        error_next = 1'b0;
        for (int j = 0; j < LANES; j++) begin
            if (bus.wb_valid_in[j]) begin
                if (busy_reg[bus.wb_reg_in[j]]) begin
                    busy_next[bus.wb_reg_in[j]] = 1'b0;
                end else if (bus.wb_reg_in[j] != '0) begin
                    error_next = 1'b1;
                end
                for (int m = 0; m < j; m++) begin
                    if (bus.wb_valid_in[m] && (bus.wb_reg_in[m] == bus.wb_reg_in[j]) &&
                        (bus.wb_reg_in[j] != '0)) begin
                        error_next = 1'b1;
                    end
                end
            end
        end
        for (int i = 0; i < LANES; i++) begin
            if (bus.lane_fire_in[i]) begin
                if (!grant[i]) begin
                    error_next = 1'b1;
                end
                if (bus.lane_rd_used_in[i] && (bus.lane_rd_in[i] != '0)) begin
                    busy_next[bus.lane_rd_in[i]] = 1'b1;
                end
            end
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_reg        <= '0;
            outstanding_reg <= '0;
            error_reg       <= 1'b0;
        end else if (bus.flush_in) begin
            busy_reg        <= '0;
            outstanding_reg <= '0;
        end else begin
            busy_reg        <= busy_next;
            outstanding_reg <= popcount(busy_next);
            error_reg       <= error_reg | error_next;
        end
    end

    assign bus.lane_grant_out  = grant;
    assign bus.busy_out        = busy_reg;
    assign bus.outstanding_out = outstanding_reg;
    assign bus.error_out       = error_reg;
endmodule
